// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage -- ALU plus iterative RV32M multiply/divide unit, feeding the EX/MEM register.
// Latency: ALU ops register in 1 cycle; MD ops occupy EX for a fixed 34 cycles (start, 32 iterations, result write).
// Backpressure: stall_ex (combinational) holds all ID/EX inputs during MD; flush_ex aborts any MD and writes a bubble.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ctrl_ex,
    input  logic [31:0] rd_ex,
    input  logic [31:0] pc_ex,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic        alu_src,
    input  logic [3:0]  alu_op,
    input  logic        md_en,
    input  logic [2:0]  md_op,
    input  logic        flush_ex,
    output logic [4:0]  ctrl_mem,
    output logic [31:0] rd_mem,
    output logic [31:0] pc4_mem,
    output logic [31:0] alu_result,
    output logic [31:0] write_data1,
    output logic        stall_ex
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    // Everything the final sign/selection fix-up needs, captured when an MD op starts.
    typedef struct packed {
        logic        is_div;    // divide family (md_op[2])
        logic        hi_sel;    // multiply: return the upper product word
        logic        rem_sel;   // divide: return the remainder
        logic        neg_res;   // product / quotient must be negated
        logic        neg_rem;   // remainder must be negated (follows the dividend)
        logic        div_zero;  // divisor was zero
        logic [31:0] dividend;  // original dividend, returned as remainder on divide-by-zero
    } md_ctx_t;

    // Operand selection
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;

    assign op_a  = rs1_data;
    assign op_b  = alu_src ? imm : rs2_data;
    assign shamt = op_b[4:0];

    // Single-cycle ALU.
    logic [31:0] alu_out;

    always_comb begin
        alu_out = 32'd0;
        case (alu_op)
            4'd0:    alu_out = op_a + op_b;
            4'd1:    alu_out = op_a - op_b;
            4'd2:    alu_out = op_a << shamt;
            4'd3:    alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
            4'd4:    alu_out = {31'd0, op_a < op_b};
            4'd5:    alu_out = op_a ^ op_b;
            4'd6:    alu_out = op_a >> shamt;
            4'd7:    alu_out = $signed(op_a) >>> shamt;
            4'd8:    alu_out = op_a | op_b;
            4'd9:    alu_out = op_a & op_b;
            4'd10:   alu_out = op_b;
            default: alu_out = 32'd0;
        endcase
    end

    // MD control state
    md_state_t   state;
    md_state_t   state_nx;
    logic [4:0]  cnt;
    logic        md_start;
    logic        md_step;

    // MD datapath state: acc holds {upper product, multiplier} or {partial remainder, dividend/quotient}.
    logic [63:0] acc;
    logic [31:0] b_mag;
    md_ctx_t     ctx;
    md_ctx_t     ctx_nx;

    // Sign handling at start: the core iterates on unsigned magnitudes only.
    logic        sgn_a;
    logic        sgn_b;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag_nx;
    logic [31:0] b_mag_nx;

    // Decode which operands are treated as signed and take their magnitudes.
    always_comb begin
        sgn_a    = (md_op == 3'd1) || (md_op == 3'd2) || (md_op == 3'd4) || (md_op == 3'd6);
        sgn_b    = (md_op == 3'd1) || (md_op == 3'd4) || (md_op == 3'd6);
        a_neg    = sgn_a && op_a[31];
        b_neg    = sgn_b && op_b[31];
        a_mag_nx = a_neg ? (32'd0 - op_a) : op_a;
        b_mag_nx = b_neg ? (32'd0 - op_b) : op_b;

        ctx_nx          = '0;
        ctx_nx.is_div   = md_op[2];
        ctx_nx.hi_sel   = (md_op[1:0] != 2'd0);
        ctx_nx.rem_sel  = md_op[1];
        ctx_nx.neg_res  = a_neg ^ b_neg;
        ctx_nx.neg_rem  = a_neg;
        ctx_nx.div_zero = (op_b == 32'd0);
        ctx_nx.dividend = op_a;
    end

    // FSM next state and stall; flush overrides everything, reset masks the stall immediately.
    always_comb begin
        state_nx = state;
        stall_ex = 1'b0;
        md_start = 1'b0;
        md_step  = 1'b0;
        case (state)
            IDLE: begin
                if (md_en) begin
                    stall_ex = 1'b1;
                    md_start = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                stall_ex = 1'b1;
                md_step  = 1'b1;
                if (cnt == 5'd31) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (flush_ex) begin
            state_nx = IDLE;
            stall_ex = 1'b0;
            md_start = 1'b0;
            md_step  = 1'b0;
        end
        if (reset) begin
            stall_ex = 1'b0;
        end
    end

    // FSM state and iteration counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_nx;
            if (md_start) begin
                cnt <= 5'd0;
            end else if (md_step) begin
                cnt <= cnt + 5'd1;
            end
        end
    end

    // One shift-add multiply step: add multiplicand when the current multiplier bit is set, then shift right.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
    end

    // One restoring-divide step: shift in the next dividend bit, subtract the divisor if it fits.
    logic [32:0] div_shift;
    logic        div_ok;
    logic [31:0] div_sub;
    logic [63:0] div_next;

    always_comb begin
        div_shift = {acc[63:32], acc[31]};
        div_ok    = (div_shift >= {1'b0, b_mag});
        div_sub   = div_shift[31:0] - b_mag;
        div_next  = {(div_ok ? div_sub : div_shift[31:0]), acc[30:0], div_ok};
    end

    // MD datapath registers: load magnitudes on start, iterate while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= 64'd0;
            b_mag <= 32'd0;
            ctx   <= '0;
        end else if (md_start) begin
            acc   <= {32'd0, a_mag_nx};
            b_mag <= b_mag_nx;
            ctx   <= ctx_nx;
        end else if (md_step) begin
            acc   <= ctx.is_div ? div_next : mul_next;
        end
    end

    // Final sign correction and result selection, consumed in DONE.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] mul_res;
    logic [31:0] div_res;
    logic [31:0] md_result;

    always_comb begin
        prod_fix = ctx.neg_res ? (64'd0 - acc) : acc;
        quo_fix  = ctx.neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_fix  = ctx.neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
        mul_res  = ctx.hi_sel ? prod_fix[63:32] : prod_fix[31:0];
        if (ctx.div_zero) begin
            div_res = ctx.rem_sel ? ctx.dividend : 32'hFFFF_FFFF;
        end else begin
            div_res = ctx.rem_sel ? rem_fix : quo_fix;
        end
        md_result = ctx.is_div ? div_res : mul_res;
    end

    // EX/MEM register: real instruction when neither stalled nor flushed, bubble otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_mem    <= 5'd0;
            rd_mem      <= 32'd0;
            pc4_mem     <= 32'd0;
            alu_result  <= 32'd0;
            write_data1 <= 32'd0;
        end else if (!stall_ex && !flush_ex) begin
            ctrl_mem    <= ctrl_ex;
            rd_mem      <= rd_ex;
            pc4_mem     <= pc_ex + 32'd4;
            alu_result  <= (state == DONE) ? md_result : alu_out;
            write_data1 <= rs2_data;
        end else begin
            ctrl_mem    <= 5'd0;
            rd_mem      <= 32'd0;
            pc4_mem     <= 32'd0;
            alu_result  <= 32'd0;
            write_data1 <= 32'd0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage -- ALU ops, RV32M ops, back-to-back MD, flush and async reset.
// Latency: expects 1 cycle for ALU, 33 stalled cycles plus one result cycle for MD.
// Backpressure: inputs are held while stall_ex is high and advanced only after a non-stalled edge.
module tb_ex_stage;

    logic        clk;
    logic        reset;
    logic [4:0]  ctrl_ex;
    logic [31:0] rd_ex;
    logic [31:0] pc_ex;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic        md_en;
    logic [2:0]  md_op;
    logic        flush_ex;
    logic [4:0]  ctrl_mem;
    logic [31:0] rd_mem;
    logic [31:0] pc4_mem;
    logic [31:0] alu_result;
    logic [31:0] write_data1;
    logic        stall_ex;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [4:0]  ctrl;
        logic [31:0] rd;
        logic [31:0] pc4;
        logic [31:0] res;
        logic [31:0] wd;
    } exp_t;

    exp_t sb_q[$];

    ex_stage dut (
        .clk         (clk),
        .reset       (reset),
        .ctrl_ex     (ctrl_ex),
        .rd_ex       (rd_ex),
        .pc_ex       (pc_ex),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .imm         (imm),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .md_en       (md_en),
        .md_op       (md_op),
        .flush_ex    (flush_ex),
        .ctrl_mem    (ctrl_mem),
        .rd_mem      (rd_mem),
        .pc4_mem     (pc4_mem),
        .alu_result  (alu_result),
        .write_data1 (write_data1),
        .stall_ex    (stall_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU.
    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> b[4:0];
            4'd7:    return sa >>> b[4:0];
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    // Reference RV32M using wide native arithmetic.
    function automatic logic [31:0] model_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] ub_s;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        p;
        int                 ia;
        int                 ib;
        logic               ovf;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ua   = {32'd0, a};
        ub   = {32'd0, b};
        ub_s = ub;
        ia   = a;
        ib   = b;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = ua * ub;   return p[31:0];  end
            3'd1: begin p = sa * sb;   return p[63:32]; end
            3'd2: begin p = sa * ub_s; return p[63:32]; end
            3'd3: begin p = ua * ub;   return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                return ia % ib;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Presents one instruction at a negedge and holds it until an edge with stall_ex low, then goes idle.
    task automatic run_instr(input logic [4:0] c, input logic [31:0] rd, input logic [31:0] pc,
                             input logic [31:0] a, input logic [31:0] b2, input logic [31:0] im,
                             input logic src, input logic [3:0] aop, input logic men, input logic [2:0] mop,
                             output int stalls, output logic ok);
        logic st;
        @(negedge clk);
        ctrl_ex  = c;
        rd_ex    = rd;
        pc_ex    = pc;
        rs1_data = a;
        rs2_data = b2;
        imm      = im;
        alu_src  = src;
        alu_op   = aop;
        md_en    = men;
        md_op    = mop;
        stalls   = 0;
        ok       = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            st = stall_ex;
            @(posedge clk);
            #1;
            if (!st) begin
                ok = 1'b1;
            end else begin
                stalls++;
                @(negedge clk);
            end
        end
        md_en   = 1'b0;
        ctrl_ex = 5'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #7;
        checks++; if (ctrl_mem !== 5'd0) begin errors++; $display("FAIL reset_ctrl_mem got=%h exp=0", ctrl_mem); end
        checks++; if (rd_mem !== 32'd0) begin errors++; $display("FAIL reset_rd_mem got=%h exp=0", rd_mem); end
        checks++; if (pc4_mem !== 32'd0) begin errors++; $display("FAIL reset_pc4_mem got=%h exp=0", pc4_mem); end
        checks++; if (alu_result !== 32'd0) begin errors++; $display("FAIL reset_alu_result got=%h exp=0", alu_result); end
        checks++; if (write_data1 !== 32'd0) begin errors++; $display("FAIL reset_write_data1 got=%h exp=0", write_data1); end
        checks++; if (stall_ex !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_ex); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_alu();
        logic [3:0]  ops [12];
        logic [31:0] av [12];
        logic [31:0] bv [12];
        logic [31:0] pcv [12];
        logic        srcv [12];
        ops  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd13};
        av   = '{32'hFFFF_FFFF, 32'd5, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_1234,
                 32'h8000_0000, 32'h8000_0000, 32'h0F00_00F0, 32'h0FF0_F00F, 32'h1111_1111, 32'h1234_5678};
        bv   = '{32'd1, 32'd7, 32'h0000_0021, 32'd1, 32'd1, 32'h0FF0_4321,
                 32'd4, 32'd4, 32'h00F0_0F00, 32'h00FF_FF00, 32'hCAFE_BABE, 32'h9ABC_DEF0};
        pcv  = '{32'hFFFF_FFFC, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h110,
                 32'h114, 32'h118, 32'h11C, 32'h120, 32'h124, 32'h128};
        srcv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 12; i++) begin
            logic [31:0] rs2v;
            logic [31:0] immv;
            exp_t        e;
            exp_t        got;
            int          st;
            logic        ok;
            rs2v = srcv[i] ? ~bv[i] : bv[i];
            immv = srcv[i] ? bv[i] : ~bv[i];
            e = '{ctrl: 5'(i + 1), rd: 32'(i + 3), pc4: pcv[i] + 32'd4, res: model_alu(ops[i], av[i], bv[i]), wd: rs2v};
            sb_q.push_back(e);
            run_instr(5'(i + 1), 32'(i + 3), pcv[i], av[i], rs2v, immv, srcv[i], ops[i], 1'b0, 3'd0, st, ok);
            checks++;
            if (!ok || st != 0) begin errors++; $display("FAIL alu_latency op=%0d stalls=%0d ok=%b exp stalls=0", ops[i], st, ok); end
            got = '{ctrl: ctrl_mem, rd: rd_mem, pc4: pc4_mem, res: alu_result, wd: write_data1};
            e = sb_q.pop_front();
            checks++;
            if (got !== e) begin errors++; $display("FAIL alu_record op=%0d got=%h exp=%h", ops[i], got, e); end
        end
    endtask

    task automatic test_md();
        logic [2:0]  ops [14];
        logic [31:0] av [14];
        logic [31:0] bv [14];
        ops = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd4, 3'd6, 3'd6, 3'd4, 3'd5, 3'd7, 3'd4, 3'd6};
        av  = '{32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7,
                32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                32'hFFFF_FFF9, 32'hFFFF_FFF9};
        bv  = '{32'h8000_0000, 32'h9ABC_DEF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 18; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            exp_t        e;
            exp_t        got;
            int          st;
            logic        ok;
            if (i < 14) begin
                op = ops[i]; a = av[i]; b = bv[i];
            end else begin
                op = 3'($urandom_range(7, 0)); a = $urandom; b = $urandom;
            end
            e = '{ctrl: 5'h11 + 5'(i), rd: 32'(i + 9), pc4: 32'h2000 + 32'(4 * i) + 32'd4, res: model_md(op, a, b), wd: b};
            sb_q.push_back(e);
            run_instr(5'h11 + 5'(i), 32'(i + 9), 32'h2000 + 32'(4 * i), a, b, 32'h5A5A_5A5A, 1'b0, 4'd0, 1'b1, op, st, ok);
            checks++;
            if (!ok || st != 33) begin errors++; $display("FAIL md_stall_cycles op=%0d stalls=%0d ok=%b exp stalls=33", op, st, ok); end
            got = '{ctrl: ctrl_mem, rd: rd_mem, pc4: pc4_mem, res: alu_result, wd: write_data1};
            e = sb_q.pop_front();
            checks++;
            if (got !== e) begin errors++; $display("FAIL md_record op=%0d a=%h b=%h got=%h exp=%h", op, a, b, got, e); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            exp_t        e;
            int          st;
            logic        ok;
            a = 32'h0001_0000 + 32'(i * 77);
            b = 32'd3 + 32'(i);
            e = '{ctrl: 5'h08, rd: 32'd20, pc4: 32'h3004, res: model_md(3'(i + 4), a, b), wd: b};
            sb_q.push_back(e);
            run_instr(5'h08, 32'd20, 32'h3000, a, b, 32'd0, 1'b0, 4'd0, 1'b1, 3'(i + 4), st, ok);
            checks++;
            if (!ok || st != 33) begin errors++; $display("FAIL b2b_stall_cycles idx=%0d stalls=%0d ok=%b exp stalls=33", i, st, ok); end
            e = sb_q.pop_front();
            checks++;
            if (alu_result !== e.res) begin errors++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", i, alu_result, e.res); end
        end
    endtask

    task automatic test_flush();
        exp_t e;
        int   st;
        logic ok;
        @(negedge clk);
        ctrl_ex = 5'h1F; rd_ex = 32'd4; pc_ex = 32'h400; rs1_data = 32'd100; rs2_data = 32'd9;
        imm = 32'd0; alu_src = 1'b0; alu_op = 4'd0; md_en = 1'b1; md_op = 3'd0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        checks++; if (stall_ex !== 1'b1) begin errors++; $display("FAIL flush_busy_stall got=%b exp=1", stall_ex); end
        flush_ex = 1'b1;
        #1;
        checks++; if (stall_ex !== 1'b0) begin errors++; $display("FAIL flush_stall_drop got=%b exp=0", stall_ex); end
        @(posedge clk);
        #1;
        checks++; if (ctrl_mem !== 5'd0) begin errors++; $display("FAIL flush_bubble_ctrl got=%h exp=0", ctrl_mem); end
        checks++; if (alu_result !== 32'd0) begin errors++; $display("FAIL flush_bubble_result got=%h exp=0", alu_result); end
        flush_ex = 1'b0;
        md_en    = 1'b0;
        ctrl_ex  = 5'd0;
        e = '{ctrl: 5'h03, rd: 32'd6, pc4: 32'h408, res: 32'd300, wd: 32'd200};
        sb_q.push_back(e);
        run_instr(5'h03, 32'd6, 32'h404, 32'd100, 32'd200, 32'd0, 1'b0, 4'd0, 1'b0, 3'd0, st, ok);
        checks++;
        if (!ok || st != 0) begin errors++; $display("FAIL flush_then_alu_latency stalls=%0d ok=%b exp stalls=0", st, ok); end
        e = sb_q.pop_front();
        checks++;
        if (alu_result !== e.res || ctrl_mem !== e.ctrl) begin
            errors++; $display("FAIL flush_then_alu res=%h ctrl=%h exp res=%h ctrl=%h", alu_result, ctrl_mem, e.res, e.ctrl);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   st;
        logic ok;
        run_instr(5'h1A, 32'd7, 32'h500, 32'd1, 32'd2, 32'd0, 1'b0, 4'd0, 1'b0, 3'd0, st, ok);
        checks++; if (alu_result !== 32'd3) begin errors++; $display("FAIL areset_pre_result got=%h exp=3", alu_result); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({ctrl_mem, rd_mem, pc4_mem, alu_result, write_data1} !== 133'd0) begin
            errors++; $display("FAIL areset_outputs got=%h exp=0", {ctrl_mem, rd_mem, pc4_mem, alu_result, write_data1});
        end
        @(negedge clk);
        reset = 1'b0;
        // Start an MD op, then hit reset mid-BUSY between clock edges.
        @(negedge clk);
        ctrl_ex = 5'h0C; rd_ex = 32'd8; pc_ex = 32'h600; rs1_data = 32'd1000; rs2_data = 32'd7;
        alu_src = 1'b0; md_en = 1'b1; md_op = 3'd4;
        repeat (6) @(posedge clk);
        #3;
        checks++; if (stall_ex !== 1'b1) begin errors++; $display("FAIL areset_busy_stall got=%b exp=1", stall_ex); end
        reset = 1'b1;
        md_en = 1'b0;
        #1;
        checks++; if (stall_ex !== 1'b0) begin errors++; $display("FAIL areset_stall got=%b exp=0", stall_ex); end
        checks++; if (ctrl_mem !== 5'd0 || alu_result !== 32'd0) begin
            errors++; $display("FAIL areset_busy_outputs ctrl=%h res=%h exp 0", ctrl_mem, alu_result);
        end
        @(negedge clk);
        reset = 1'b0;
        e = '{ctrl: 5'h0D, rd: 32'd9, pc4: 32'h608, res: model_md(3'd6, 32'd1000, 32'd7), wd: 32'd7};
        sb_q.push_back(e);
        run_instr(5'h0D, 32'd9, 32'h604, 32'd1000, 32'd7, 32'd0, 1'b0, 4'd0, 1'b1, 3'd6, st, ok);
        checks++;
        if (!ok || st != 33) begin errors++; $display("FAIL areset_restart_cycles stalls=%0d ok=%b exp stalls=33", st, ok); end
        e = sb_q.pop_front();
        checks++;
        if (alu_result !== e.res || ctrl_mem !== e.ctrl) begin
            errors++; $display("FAIL areset_restart res=%h ctrl=%h exp res=%h ctrl=%h", alu_result, ctrl_mem, e.res, e.ctrl);
        end
    endtask

    initial begin
        ctrl_ex = 5'd0; rd_ex = 32'd0; pc_ex = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0; imm = 32'd0;
        alu_src = 1'b0; alu_op = 4'd0; md_en = 1'b0; md_op = 3'd0; flush_ex = 1'b0; reset = 1'b0;
        test_reset();
        test_alu();
        test_md();
        test_back_to_back();
        test_flush();
        test_async_reset();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
